// File: rtl/cpu_sequencer.sv
// T-state / M-cycle sequencer for an 8-bit CPU core: opcode fetch handshake,
// CB-prefix tracking and HALT/wake handling.
module cpu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] op_next,
    input  logic       op_valid,
    input  logic [2:0] mcycles_req,
    input  logic       halt_req,
    input  logic       wake,
    output logic [1:0] t_state,
    output logic [2:0] m_cycle,
    output logic       m1t1,
    output logic [7:0] op,
    output logic       op_load,
    output logic       cb_prefix,
    output logic       instr_done,
    output logic       halted
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] t_q, t_d;
    logic [2:0] m_q, m_d;
    logic [7:0] op_q, op_d;
    logic       op_load_q, op_load_d;
    logic       cb_q, cb_d;
    logic [2:0] last_m_s;
    logic       done_s;

    // Index of the final M-cycle: a request of 0 means one cycle, anything above 6 means six.
    function automatic logic [2:0] last_mcycle(input logic [2:0] req);
        logic [2:0] r;
        if (req == 3'd0) begin
            r = 3'd0;
        end else if (req > 3'd6) begin
            r = 3'd5;
        end else begin
            r = req - 3'd1;
        end
        return r;
    endfunction

    // Instruction completion is decoded combinationally from the live M-cycle count.
    always_comb begin
        last_m_s = last_mcycle(mcycles_req);
        done_s   = (state_q == ST_RUN) && (t_q == 2'd3) && (m_q == last_m_s);
    end

    // Next-state logic for the sequencer FSM and its datapath registers.
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        m_d       = m_q;
        op_d      = op_q;
        op_load_d = 1'b0;
        cb_d      = cb_q;
        case (state_q)
            ST_RUN: begin
                if ((t_q == 2'd1) && (m_q == 3'd0)) begin
                    if (op_valid) begin
                        op_d      = op_next;
                        op_load_d = 1'b1;
                        t_d       = 2'd2;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (t_q == 2'd3) begin
                    t_d = 2'd0;
                    if (done_s) begin
                        m_d = 3'd0;
                        // A CB opcode arms the prefix only when not already the second byte.
                        if (cb_q) begin
                            cb_d = 1'b0;
                        end else if (op_q == 8'hCB) begin
                            cb_d = 1'b1;
                        end else begin
                            cb_d = 1'b0;
                        end
                        if (halt_req && !wake) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (m_q >= 3'd5) begin
                        m_d = 3'd0;
                    end else begin
                        m_d = m_q + 3'd1;
                    end
                end else begin
                    t_d = t_q + 2'd1;
                end
            end
            ST_WAIT: begin
                if (op_valid) begin
                    op_d      = op_next;
                    op_load_d = 1'b1;
                    t_d       = 2'd2;
                    state_d   = ST_RUN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HALT: begin
                if (wake) begin
                    state_d = ST_RUN;
                    t_d     = 2'd0;
                    m_d     = 3'd0;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_RUN;
                t_d     = 2'd0;
                m_d     = 3'd0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            t_q       <= 2'd0;
            m_q       <= 3'd0;
            op_q      <= 8'h00;
            op_load_q <= 1'b0;
            cb_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            m_q       <= m_d;
            op_q      <= op_d;
            op_load_q <= op_load_d;
            cb_q      <= cb_d;
        end
    end

    assign t_state    = t_q;
    assign m_cycle    = m_q;
    assign op         = op_q;
    assign op_load    = op_load_q;
    assign cb_prefix  = cb_q;
    assign instr_done = done_s;
    assign halted     = (state_q == ST_HALT);
    assign m1t1       = (state_q == ST_RUN) && (t_q == 2'd0) && (m_q == 3'd0);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: expected per-cycle output vectors are queued
// as stimulus is applied and compared once the cycle's outputs have settled.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] op_next;
    logic       op_valid;
    logic [2:0] mcycles_req;
    logic       halt_req;
    logic       wake;
    logic [1:0] t_state;
    logic [2:0] m_cycle;
    logic       m1t1;
    logic [7:0] op;
    logic       op_load;
    logic       cb_prefix;
    logic       instr_done;
    logic       halted;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0] t;
        logic [2:0] m;
        logic       m1t1;
        logic [7:0] op;
        logic       ld;
        logic       cb;
        logic       dn;
        logic       hl;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    cpu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .op_next     (op_next),
        .op_valid    (op_valid),
        .mcycles_req (mcycles_req),
        .halt_req    (halt_req),
        .wake        (wake),
        .t_state     (t_state),
        .m_cycle     (m_cycle),
        .m1t1        (m1t1),
        .op          (op),
        .op_load     (op_load),
        .cb_prefix   (cb_prefix),
        .instr_done  (instr_done),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check_out();
        exp_t  e;
        exp_t  a;
        string tg;
        e  = sb_q.pop_front();
        tg = tag_q.pop_front();
        a  = {t_state, m_cycle, m1t1, op, op_load, cb_prefix, instr_done, halted};
        n_vec++;
        assert (a === e) else begin
            n_err++;
            $error("FAIL %s: observed t=%0d m=%0d m1t1=%b op=%h ld=%b cb=%b done=%b halt=%b, expected t=%0d m=%0d m1t1=%b op=%h ld=%b cb=%b done=%b halt=%b",
                   tg, a.t, a.m, a.m1t1, a.op, a.ld, a.cb, a.dn, a.hl,
                   e.t, e.m, e.m1t1, e.op, e.ld, e.cb, e.dn, e.hl);
        end
    endtask

    // One clock: queue expectation, check mid-cycle, advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [1:0] t, input logic [2:0] m,
                       input logic [7:0] o, input logic ld, input logic cb,
                       input logic dn, input logic hl);
        exp_t e;
        e = '{t, m, (!hl && (t == 2'd0) && (m == 3'd0)), o, ld, cb, dn, hl};
        sb_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        check_out();
        @(posedge clk);
        #1;
    endtask

    // A complete instruction: ws extra stall cycles at M1/T2, ne expected M-cycles.
    task automatic instr(input string tag, input logic [7:0] opp, input logic [7:0] opn,
                         input logic [2:0] req, input int ne, input int ws,
                         input logic cb, input logic hr, input logic wk);
        op_next     = opn;
        mcycles_req = req;
        halt_req    = hr;
        wake        = wk;
        op_valid    = 1'b0;
        cyc(tag, 2'd0, 3'd0, opp, 1'b0, cb, 1'b0, 1'b0);
        op_valid = (ws == 0);
        cyc(tag, 2'd1, 3'd0, opp, 1'b0, cb, 1'b0, 1'b0);
        for (int i = 1; i <= ws; i++) begin
            op_valid = (i == ws);
            cyc(tag, 2'd1, 3'd0, opp, 1'b0, cb, 1'b0, 1'b0);
        end
        op_valid = 1'b1;
        cyc(tag, 2'd2, 3'd0, opn, 1'b1, cb, 1'b0, 1'b0);
        cyc(tag, 2'd3, 3'd0, opn, 1'b0, cb, (ne == 1), 1'b0);
        for (int mi = 1; mi < ne; mi++) begin
            for (int ti = 0; ti < 4; ti++) begin
                cyc(tag, 2'(ti), 3'(mi), opn, 1'b0, cb, ((ti == 3) && (mi == ne - 1)), 1'b0);
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        op_next     = 8'h00;
        op_valid    = 1'b0;
        mcycles_req = 3'd1;
        halt_req    = 1'b0;
        wake        = 1'b0;
        #1;
        cyc("reset", 2'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        op_valid = 1'b1;
        op_next  = 8'hA5;
        cyc("reset_hold", 2'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        instr("nop1", 8'h00, 8'h00, 3'd1, 1, 0, 1'b0, 1'b0, 1'b0);
        instr("nop2", 8'h00, 8'h00, 3'd1, 1, 0, 1'b0, 1'b0, 1'b0);
        instr("m3", 8'h00, 8'h01, 3'd3, 3, 0, 1'b0, 1'b0, 1'b0);
        instr("stall", 8'h01, 8'h3E, 3'd1, 1, 3, 1'b0, 1'b0, 1'b0);
        instr("cb_first", 8'h3E, 8'hCB, 3'd2, 2, 0, 1'b0, 1'b0, 1'b0);
        instr("cb_second", 8'hCB, 8'hCB, 3'd2, 2, 0, 1'b1, 1'b0, 1'b0);
        instr("cb_after", 8'hCB, 8'h00, 3'd2, 2, 0, 1'b0, 1'b0, 1'b0);
        instr("req0", 8'h00, 8'h11, 3'd0, 1, 0, 1'b0, 1'b0, 1'b0);
        instr("req7", 8'h11, 8'h22, 3'd7, 6, 0, 1'b0, 1'b0, 1'b0);
        instr("halt_woken", 8'h22, 8'h33, 3'd1, 1, 0, 1'b0, 1'b1, 1'b1);
        instr("halt_instr", 8'h33, 8'h76, 3'd2, 2, 1, 1'b0, 1'b1, 1'b0);

        halt_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            op_valid = i[0];
            cyc("halted", 2'd0, 3'd0, 8'h76, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        wake = 1'b1;
        cyc("halt_wake", 2'd0, 3'd0, 8'h76, 1'b0, 1'b0, 1'b0, 1'b1);
        wake = 1'b0;
        instr("after_halt", 8'h76, 8'h44, 3'd1, 1, 0, 1'b0, 1'b0, 1'b0);

        op_next     = 8'h55;
        mcycles_req = 3'd3;
        op_valid    = 1'b1;
        cyc("mid", 2'd0, 3'd0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("mid", 2'd1, 3'd0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("mid", 2'd2, 3'd0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("mid", 2'd3, 3'd0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("mid", 2'd0, 3'd1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("mid", 2'd1, 3'd1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("mid", 2'd2, 3'd1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc("rst_mid", 2'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("rst_mid_hold", 2'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        instr("post_rst", 8'h00, 8'h66, 3'd1, 1, 0, 1'b0, 1'b0, 1'b0);

        instr("halt2", 8'h66, 8'h77, 3'd1, 1, 0, 1'b0, 1'b1, 1'b0);
        halt_req = 1'b0;
        cyc("halted2", 2'd0, 3'd0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        cyc("rst_halt", 2'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        instr("post_rst2", 8'h00, 8'h88, 3'd1, 1, 0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-low; clock clk.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 op_next  input  8  opcode byte from memory buffer.
REQ-005 op_valid  input  1  op_next valid; sampled only in M1/T2.
REQ-006 mcycles_req  input  3  M-cycle count of current instruction from decode; valid from M1/T3 onward; 0 treated as 1.
REQ-007 halt_req  input  1  decode requests HALT; sampled only on the instr_done cycle.
REQ-008 wake  input  1  interrupt/wake request; level-sensitive.
REQ-009 t_state  output  2  current T-state (0=T1 .. 3=T4).
REQ-010 m_cycle  output  3  current M-cycle index (0=M1).
REQ-011 m1t1  output  1  high while in RUN, m_cycle=0, t_state=0.
REQ-012 op  output  8  latched opcode.
REQ-013 op_load  output  1  one-cycle pulse on the cycle op is captured.
REQ-014 cb_prefix  output  1  current instruction is second byte of CB-prefixed pair.
REQ-015 instr_done  output  1  high during T4 of the last M-cycle of an instruction.
REQ-016 halted  output  1  high while in HALT state.

Function
REQ-017 The state machine SHALL have states RUN, WAIT, HALT; WAIT and HALT freeze t_state and m_cycle.
REQ-018 In RUN, t_state SHALL advance 0->1->2->3->0 once per clk.
REQ-019 At t_state=3, m_cycle SHALL increment, unless instr_done, in which case m_cycle SHALL return to 0.
REQ-020 instr_done SHALL be combinational: RUN & t_state=3 & m_cycle = max(mcycles_req,1)-1.
REQ-021 In RUN at m_cycle=0, t_state=1: if op_valid=1, op SHALL load op_next at that edge, op_load pulses, t_state advances to 2.
REQ-022 Same point with op_valid=0: next state WAIT, t_state held at 1, op unchanged, no op_load.
REQ-023 In WAIT, the first cycle with op_valid=1 SHALL load op, pulse op_load, and return to RUN with t_state=2.
REQ-024 Captured op = 0xCB with cb_prefix=0: cb_prefix SHALL set at the instr_done edge of that instruction.
REQ-025 cb_prefix SHALL clear at the instr_done edge of the following instruction; 0xCB fetched while cb_prefix=1 does not re-arm it.
REQ-026 On instr_done with halt_req=1 and wake=0: enter HALT at that edge, t_state=0, m_cycle=0, halted=1, m1t1=0.
REQ-027 On instr_done with halt_req=1 and wake=1: no HALT entry; continue to next M1.
REQ-028 In HALT, wake=1 SHALL return to RUN at the next edge with t_state=0, m_cycle=0 (m1t1 high the following cycle); op keeps last value.
REQ-029 halt_req SHALL be ignored outside the instr_done cycle; wake SHALL be ignored outside HALT.
REQ-030 m_cycle SHALL wrap-protect: never exceed 5; mcycles_req >6 treated as 6.

Reset
REQ-031 rst low SHALL force immediately: state RUN, t_state=0, m_cycle=0, op=0x00, cb_prefix=0, op_load=0, halted=0.
REQ-032 m1t1 SHALL be high during reset and on the first cycle after release.
REQ-033 Reset mid-instruction, in WAIT, or in HALT SHALL abandon the instruction with no instr_done and no op_load.

Verification
REQ-034 Reset release, op_valid=1, op_next=0x00, mcycles_req=1: m1t1 every 4 clks; op_load at T2; instr_done every T4.
REQ-035 mcycles_req=3, op_next=0x01: m_cycle 0,1,2 across 12 clks; single instr_done at m_cycle=2/T4; next m1t1 on clk 13.
REQ-036 op_valid=0 for 3 cycles at M1/T2: t_state holds 1 for 4 cycles; op loads 0x3E on 4th; instruction 3 clks longer.
REQ-037 op_next=0xCB then 0xCB (mcycles_req=2 each): cb_prefix=0 for the first instruction, 1 for the second, 0 after the second's instr_done.
REQ-038 halt_req=1 at instr_done, wake=0 for 10 clks then 1: halted=1 for 10 clks, t_state frozen at 0; next edge RUN; m1t1 high one cycle later.
REQ-039 rst asserted at m_cycle=1/T3 and while halted: all outputs at reset values immediately; m1t1 first cycle after release.
